// File: rtl/vjtag_wb_burst_master.sv
// Wishbone burst master behind the JTAG debug port: command/write-data streams in, read data out via a small FIFO.
// Optional bus watchdog enabled by defining VJTAG_WB_TIMEOUT_EN.
module vjtag_wb_burst_master #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int SELw        = 4,
  parameter int TAGw        = 3,
  parameter int LENw        = 8,
  parameter int RFIFO_DEPTH = 4,
  parameter int ADDR_STEP   = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [LENw-1:0] cmd_len_i,
  input  logic [SELw-1:0] cmd_sel_i,
  input  logic            wdat_valid_i,
  output logic            wdat_ready_o,
  input  logic [DW-1:0]   wdat_i,
  output logic            rdat_valid_o,
  input  logic            rdat_ready_i,
  output logic [DW-1:0]   rdat_o,
  output logic            busy_o,
  output logic [1:0]      err_o,
  output logic [SELw-1:0] m_sel_o,
  output logic [DW-1:0]   m_dat_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [TAGw-1:0] m_cti_o,
  output logic            m_stb_o,
  output logic            m_cyc_o,
  output logic            m_we_o,
  input  logic [DW-1:0]   m_dat_i,
  input  logic            m_ack_i,
  input  logic            m_err_i
);

  localparam int PW = $clog2(RFIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WR_FETCH, S_WR_BUS, S_RD_BUS} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LENw-1:0] rem_q, rem_d;
  logic            single_q, single_d;
  logic [SELw-1:0] sel_q, sel_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [1:0]      err_q, err_d;
  logic            started_q, started_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   mem [RFIFO_DEPTH];

  logic push, pop, beat_ack, beat_abort, wd_fire;

  // Bus-side outputs are pure functions of registered state; stb on reads is throttled by FIFO room
  always_comb begin
    cmd_ready_o  = (state_q == S_IDLE) & ~reset;
    wdat_ready_o = (state_q == S_WR_FETCH);
    busy_o       = (state_q != S_IDLE);
    err_o        = err_q;
    m_stb_o      = (state_q == S_WR_BUS) |
                   ((state_q == S_RD_BUS) & (cnt_q < CW'(RFIFO_DEPTH)));
    m_cyc_o      = (state_q == S_WR_BUS) | (state_q == S_RD_BUS) |
                   ((state_q == S_WR_FETCH) & started_q);
    m_we_o       = (state_q == S_WR_BUS) | ((state_q == S_WR_FETCH) & started_q);
    m_addr_o     = addr_q;
    m_sel_o      = sel_q;
    m_dat_o      = wdat_q;
    m_cti_o      = '0;
    if (m_cyc_o && !single_q) m_cti_o = (rem_q == '0) ? TAGw'(3'b111) : TAGw'(3'b010);
    rdat_valid_o = (cnt_q != '0);
    rdat_o       = rdat_valid_o ? mem[rptr_q] : '0;
  end

`ifdef VJTAG_WB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;

  // Counts consecutive stb cycles without a response; fires on the TIMEOUT-th such cycle
  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if (m_stb_o && !m_ack_i && !m_err_i) begin
      if (wd_q == WDW'(TIMEOUT - 1)) wd_fire = 1'b1;
      else                           wd_d    = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  // No watchdog: stb waits indefinitely for ack/err
  assign wd_fire = 1'b0 && (TIMEOUT != 0);
`endif

  assign beat_ack   = m_stb_o & m_ack_i & ~m_err_i;
  assign beat_abort = m_stb_o & (m_err_i | wd_fire);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    single_d  = single_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    err_d     = err_q;
    started_d = started_q;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d    = cmd_addr_i;
          rem_d     = cmd_len_i;
          single_d  = (cmd_len_i == '0);
          sel_d     = cmd_sel_i;
          err_d     = 2'b00;
          started_d = 1'b0;
          state_d   = cmd_we_i ? S_WR_FETCH : S_RD_BUS;
        end
      end
      S_WR_FETCH: begin
        if (wdat_valid_i) begin
          wdat_d  = wdat_i;
          state_d = S_WR_BUS;
        end
      end
      S_WR_BUS, S_RD_BUS: begin
        if (beat_abort) begin
          // err takes priority over ack; a watchdog expiry is only reported when the slave gave no err
          if (m_err_i) err_d[0] = 1'b1;
          else         err_d[1] = 1'b1;
          state_d = S_IDLE;
        end else if (beat_ack) begin
          addr_d = addr_q + AW'(ADDR_STEP);
          rem_d  = rem_q - LENw'(1);
          push   = (state_q == S_RD_BUS);
          if (rem_q == '0)               state_d = S_IDLE;
          else if (state_q == S_WR_BUS) begin
            state_d   = S_WR_FETCH;
            started_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop    = rdat_ready_i & (cnt_q != '0);
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      single_q  <= 1'b1;
      sel_q     <= '0;
      wdat_q    <= '0;
      err_q     <= '0;
      started_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      single_q  <= single_d;
      sel_q     <= sel_d;
      wdat_q    <= wdat_d;
      err_q     <= err_d;
      started_q <= started_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // FIFO storage carries no reset; validity comes from the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= m_dat_i;
  end

endmodule
